// File: rtl/td4_prog_loader.sv
// Program loader and run controller for the MY_TD4 core: loads the 16x8 program ROM from a
// checksummed byte frame and drives the core's reset and clock-enable (run / step / halt).
module td4_prog_loader #(
   parameter int unsigned WORDS   = 16,
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_valid,
   output logic                  o_rx_ready,
   output logic [WORDS*DW-1:0]   o_rom_flat,
   output logic                  o_cpu_rst_n,
   output logic                  o_cpu_clk_en,
   output logic                  o_prog_valid,
   output logic                  o_busy,
   output logic                  o_err
);

   localparam int unsigned CW = $clog2(WORDS);
   localparam int unsigned TW = $clog2(TIMEOUT);

   localparam logic [7:0] CMD_LOAD = 8'hA5;
   localparam logic [7:0] CMD_RUN  = 8'h52;
   localparam logic [7:0] CMD_STEP = 8'h53;
   localparam logic [7:0] CMD_HALT = 8'h48;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_CHK    = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t              r_state;
   logic [CW-1:0]       r_cnt;
   logic [7:0]          r_sum;
   logic [TW-1:0]       r_timer;
   logic [DW-1:0]       r_shadow [WORDS];
   logic [WORDS*DW-1:0] r_rom;
   logic                r_cpu_rst_n;
   logic                r_clk_en;
   logic                r_run;
   logic                r_prog_valid;
   logic                r_err;
   logic                r_busy;

   state_t              w_state_nxt;
   logic [CW-1:0]       w_cnt_nxt;
   logic [7:0]          w_sum_nxt;
   logic [TW-1:0]       w_timer_nxt;
   logic                w_cpu_rst_n_nxt;
   logic                w_clk_en_nxt;
   logic                w_run_nxt;
   logic                w_prog_valid_nxt;
   logic                w_err_nxt;
   logic                w_shadow_we;
   logic                w_commit;
   logic                w_rx_ready;
   logic                w_xfer;
   logic [WORDS*DW-1:0] w_shadow_flat;

   // Ready is decoded from state; bytes are stalled during the commit cycle and in reset.
   assign w_rx_ready = i_rst_n & (r_state != S_COMMIT);
   assign w_xfer     = i_rx_valid & w_rx_ready;

   always_comb begin
      w_shadow_flat = '0;
      for (int i = 0; i < int'(WORDS); i++) begin
         w_shadow_flat[DW*i +: DW] = r_shadow[i];
      end
   end

   // Next-state and registered-output decode.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_sum_nxt        = r_sum;
      w_timer_nxt      = r_timer;
      w_cpu_rst_n_nxt  = r_cpu_rst_n;
      w_clk_en_nxt     = r_clk_en;
      w_run_nxt        = r_run;
      w_prog_valid_nxt = r_prog_valid;
      w_err_nxt        = r_err;
      w_shadow_we      = 1'b0;
      w_commit         = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_clk_en_nxt = r_run;
            if (w_xfer) begin
               case (i_rx_data)
                  CMD_LOAD: begin
                     w_state_nxt     = S_LOAD;
                     w_cnt_nxt       = '0;
                     w_sum_nxt       = '0;
                     w_timer_nxt     = '0;
                     w_cpu_rst_n_nxt = 1'b0;
                     w_clk_en_nxt    = 1'b0;
                     w_run_nxt       = 1'b0;
                     w_err_nxt       = 1'b0;
                  end
                  CMD_RUN: begin
                     if (r_prog_valid) begin
                        w_run_nxt    = 1'b1;
                        w_clk_en_nxt = 1'b1;
                        w_err_nxt    = 1'b0;
                     end else begin
                        w_err_nxt    = 1'b1;
                     end
                  end
                  CMD_STEP: begin
                     if (r_prog_valid) begin
                        w_run_nxt    = 1'b0;
                        w_clk_en_nxt = 1'b1;
                        w_err_nxt    = 1'b0;
                     end else begin
                        w_err_nxt    = 1'b1;
                     end
                  end
                  CMD_HALT: begin
                     w_run_nxt    = 1'b0;
                     w_clk_en_nxt = 1'b0;
                     w_err_nxt    = 1'b0;
                  end
                  default: w_err_nxt = 1'b1;
               endcase
            end
         end
         S_LOAD: begin
            if (w_xfer) begin
               w_shadow_we = 1'b1;
               w_sum_nxt   = r_sum + i_rx_data;
               w_cnt_nxt   = r_cnt + CW'(1);
               w_timer_nxt = '0;
               if (r_cnt == CW'(WORDS - 1)) begin
                  w_state_nxt = S_CHK;
               end
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
               w_state_nxt = S_IDLE;
               w_err_nxt   = 1'b1;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         S_CHK: begin
            if (w_xfer) begin
               w_timer_nxt = '0;
               if (i_rx_data == r_sum) begin
                  w_state_nxt = S_COMMIT;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_err_nxt   = 1'b1;
               end
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
               w_state_nxt = S_IDLE;
               w_err_nxt   = 1'b1;
            end else begin
               w_timer_nxt = r_timer + TW'(1);
            end
         end
         S_COMMIT: begin
            w_commit         = 1'b1;
            w_prog_valid_nxt = 1'b1;
            w_cpu_rst_n_nxt  = 1'b1;
            w_clk_en_nxt     = 1'b0;
            w_run_nxt        = 1'b0;
            w_state_nxt      = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_sum        <= '0;
         r_timer      <= '0;
         r_cpu_rst_n  <= 1'b0;
         r_clk_en     <= 1'b0;
         r_run        <= 1'b0;
         r_prog_valid <= 1'b0;
         r_err        <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_sum        <= w_sum_nxt;
         r_timer      <= w_timer_nxt;
         r_cpu_rst_n  <= w_cpu_rst_n_nxt;
         r_clk_en     <= w_clk_en_nxt;
         r_run        <= w_run_nxt;
         r_prog_valid <= w_prog_valid_nxt;
         r_err        <= w_err_nxt;
         r_busy       <= (w_state_nxt != S_IDLE);
      end
   end

   // Shadow buffer collects the frame; the ROM image is replaced whole in the commit cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(WORDS); i++) begin
            r_shadow[i] <= '0;
         end
         r_rom <= '0;
      end else begin
         if (w_shadow_we) begin
            r_shadow[r_cnt] <= DW'(i_rx_data);
         end
         if (w_commit) begin
            r_rom <= w_shadow_flat;
         end
      end
   end

   assign o_rx_ready   = w_rx_ready;
   assign o_rom_flat   = r_rom;
   assign o_cpu_rst_n  = r_cpu_rst_n;
   assign o_cpu_clk_en = r_clk_en;
   assign o_prog_valid = r_prog_valid;
   assign o_busy       = r_busy;
   assign o_err        = r_err;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Bench for td4_prog_loader: a frame-level reference model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_td4_prog_loader;

   localparam int unsigned WORDS   = 16;
   localparam int unsigned DW      = 8;
   localparam int unsigned TIMEOUT = 1024;
   localparam int unsigned RW      = WORDS * DW;

   localparam logic [RW-1:0] ROM1 = 128'hB0B8B8BC_B6B3B1B1_B3B6BCB8_B8BCB6B3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_valid = 1'b0;
   logic          rx_ready;
   logic [RW-1:0] rom_flat;
   logic          cpu_rst_n;
   logic          cpu_clk_en;
   logic          prog_valid;
   logic          busy;
   logic          err;

   logic [7:0] frame1 [16] = '{8'hB3, 8'hB6, 8'hBC, 8'hB8, 8'hB8, 8'hBC, 8'hB6, 8'hB3,
                               8'hB1, 8'hB1, 8'hB3, 8'hB6, 8'hBC, 8'hB8, 8'hB8, 8'hB0};

   int n_tests = 0;
   int n_fail  = 0;
   int n_rdy_low  = 0;
   int n_en_high  = 0;

   td4_prog_loader #(.WORDS(WORDS), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_rx_data    (rx_data),
      .i_rx_valid   (rx_valid),
      .o_rx_ready   (rx_ready),
      .o_rom_flat   (rom_flat),
      .o_cpu_rst_n  (cpu_rst_n),
      .o_cpu_clk_en (cpu_clk_en),
      .o_prog_valid (prog_valid),
      .o_busy       (busy),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_w(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame-level view (queue of received bytes, idle counter)
   logic [7:0] m_rom [WORDS];
   logic [7:0] m_buf [$];
   bit m_pv = 0, m_err = 0, m_crst = 0, m_en = 0, m_run = 0, m_inframe = 0, m_commit = 0;
   int m_idle = 0;

   function automatic logic [7:0] buf_sum();
      logic [7:0] s;
      s = 8'h00;
      foreach (m_buf[i]) s = s + m_buf[i];
      return s;
   endfunction

   function automatic logic [RW-1:0] model_rom();
      logic [RW-1:0] f;
      f = '0;
      for (int i = 0; i < int'(WORDS); i++) f[8*i +: 8] = m_rom[i];
      return f;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(WORDS); i++) m_rom[i] = 8'h00;
         m_buf.delete();
         m_pv = 0; m_err = 0; m_crst = 0; m_en = 0; m_run = 0;
         m_inframe = 0; m_commit = 0; m_idle = 0;
      end else begin
         bit xfer;
         xfer = rx_valid && !m_commit;
         if (m_commit) begin
            for (int i = 0; i < int'(WORDS); i++) m_rom[i] = m_buf[i];
            m_pv = 1; m_crst = 1; m_en = 0; m_commit = 0;
         end else if (m_inframe) begin
            if (xfer) begin
               m_idle = 0;
               if (m_buf.size() < int'(WORDS)) begin
                  m_buf.push_back(rx_data);
               end else begin
                  m_inframe = 0;
                  if (rx_data == buf_sum()) m_commit = 1;
                  else m_err = 1;
               end
            end else begin
               m_idle++;
               if (m_idle == int'(TIMEOUT)) begin
                  m_inframe = 0;
                  m_err = 1;
               end
            end
         end else begin
            m_en = m_run;
            if (xfer) begin
               case (rx_data)
                  8'hA5: begin
                     m_inframe = 1; m_buf.delete(); m_idle = 0;
                     m_crst = 0; m_en = 0; m_run = 0; m_err = 0;
                  end
                  8'h52: if (m_pv) begin m_run = 1; m_en = 1; m_err = 0; end else m_err = 1;
                  8'h53: if (m_pv) begin m_run = 0; m_en = 1; m_err = 0; end else m_err = 1;
                  8'h48: begin m_run = 0; m_en = 0; m_err = 0; end
                  default: m_err = 1;
               endcase
            end
         end
      end
   end

   // Every-cycle comparison against the model, plus activity counters for the directed checks
   always @(negedge clk) begin
      check1("rx_ready",   rx_ready,   rst_n && !m_commit);
      check1("cpu_rst_n",  cpu_rst_n,  m_crst);
      check1("cpu_clk_en", cpu_clk_en, m_en);
      check1("prog_valid", prog_valid, m_pv);
      check1("busy",       busy,       m_inframe || m_commit);
      check1("err",        err,        m_err);
      check_w("rom_flat",  rom_flat,   model_rom());
      if (rst_n) begin
         if (!rx_ready)  n_rdy_low++;
         if (cpu_clk_en) n_en_high++;
      end
   end

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Present a byte and return 2 time units after the edge that transferred it (valid left high)
   task automatic send(input logic [7:0] b);
      bit done;
      bit rdy;
      done = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         rdy = rx_ready;
         @(posedge clk);
         #2;
         if (rdy) done = 1;
      end
      check1("send_handshake", done, 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check1({tag, "_rx_ready"},   rx_ready,   1'b0);
      check_w({tag, "_rom"},       rom_flat,   '0);
      check1({tag, "_cpu_rst_n"},  cpu_rst_n,  1'b0);
      check1({tag, "_clk_en"},     cpu_clk_en, 1'b0);
      check1({tag, "_prog_valid"}, prog_valid, 1'b0);
      check1({tag, "_busy"},       busy,       1'b0);
      check1({tag, "_err"},        err,        1'b0);
   endtask

   initial begin
      int base_r;
      int base_e;
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_r;
      int base_e;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Commands before any program: RUN and junk flag err, HALT clears it
      send(8'h52); idle(2);
      check1("run_noprog_err", err, 1'b1);
      check1("run_noprog_en", cpu_clk_en, 1'b0);
      send(8'h00); idle(2);
      check1("junk_err", err, 1'b1);
      send(8'h48); idle(2);
      check1("halt_clears_err", err, 1'b0);

      // Bad checksum, bytes with gaps
      send(8'hA5);
      for (int i = 0; i < 16; i++) begin
         send(frame1[i]);
         idle(i % 3);
      end
      send(8'h60); idle(3);
      check1("badchk_err", err, 1'b1);
      check_w("badchk_rom", rom_flat, '0);
      check1("badchk_pv", prog_valid, 1'b0);
      check1("badchk_crst", cpu_rst_n, 1'b0);
      check1("badchk_busy", busy, 1'b0);

      // Good frame with valid held high, followed directly by STEP
      base_r = n_rdy_low;
      base_e = n_en_high;
      send(8'hA5);
      for (int i = 0; i < 16; i++) send(frame1[i]);
      send(8'h61);
      send(8'h53);
      idle(4);
      check_i("commit_stall_cycles", n_rdy_low - base_r, 1);
      check_i("step_en_cycles", n_en_high - base_e, 1);
      check_w("good_rom", rom_flat, ROM1);
      check_w("model_rom_pin", model_rom(), ROM1);
      check1("good_rom_word0", (rom_flat[7:0] == 8'hB3), 1'b1);
      check1("good_rom_word15", (rom_flat[127:120] == 8'hB0), 1'b1);
      check1("good_pv", prog_valid, 1'b1);
      check1("good_crst", cpu_rst_n, 1'b1);
      check1("good_err", err, 1'b0);

      // RUN holds enable, HALT drops it the next cycle
      send(8'h52);
      check1("run_en_next", cpu_clk_en, 1'b1);
      idle(5);
      check1("run_en_held", cpu_clk_en, 1'b1);
      send(8'h48);
      check1("halt_en_next", cpu_clk_en, 1'b0);
      idle(2);

      // LOAD while running, abandoned after 8 data bytes
      send(8'h52);
      send(8'hA5);
      for (int i = 0; i < 8; i++) send(8'(i * 17 + 3));
      idle(int'(TIMEOUT) - 1);
      check1("timeout_not_yet_busy", busy, 1'b1);
      check1("timeout_not_yet_err", err, 1'b0);
      idle(1);
      check1("timeout_err", err, 1'b1);
      check1("timeout_busy", busy, 1'b0);
      check1("timeout_crst", cpu_rst_n, 1'b0);
      check1("timeout_en", cpu_clk_en, 1'b0);
      check_w("timeout_rom", rom_flat, ROM1);
      check1("timeout_pv", prog_valid, 1'b1);
      idle(2);

      // Reset at byte 5 of a frame
      send(8'hA5);
      for (int i = 0; i < 4; i++) send(8'(i + 1));
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      #1;
      check_reset_outputs("midframe_reset");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Fresh load of 0..15 (checksum 0x78) then RUN
      send(8'hA5);
      for (int i = 0; i < 16; i++) send(8'(i));
      send(8'h78);
      idle(3);
      check_w("ramp_rom", rom_flat, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
      check1("ramp_crst", cpu_rst_n, 1'b1);
      send(8'h52);
      idle(2);
      check1("ramp_run_en", cpu_clk_en, 1'b1);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
